// File: rtl/axi_lite_mem_model_if.sv
// AXI4-Lite bus bundle used between a bench master and the memory model.
// Parameters must match the attached axi_lite_mem_model instance.
interface axi_lite_mem_model_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Write address channel
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    // Write data channel
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    // Write response channel
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    // Read address channel
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    // Read data channel
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_mem_model.sv
// AXI4-Lite slave memory model with configurable depth, base address and
// read/write wait states. Out-of-range accesses answer SLVERR. AW and W are
// buffered independently; read and write channels run fully in parallel.
// The word array mem[] is meant to be preloaded and inspected hierarchically.
module axi_lite_mem_model #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    RD_LATENCY = 0,
    parameter int                    WR_LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axi_lite_mem_model_if.slave   bus
);

    localparam int          STRB_W     = DATA_WIDTH / 8;
    localparam int          BYTE_SHIFT = (STRB_W > 1) ? $clog2(STRB_W) : 0;
    localparam int          IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [63:0] MEM_BYTES  = 64'(MEM_WORDS) * 64'(STRB_W);
    localparam logic [7:0]  WR_LAT_M1  = 8'((WR_LATENCY > 0) ? WR_LATENCY - 1 : 0);
    localparam logic [7:0]  RD_LAT     = 8'(RD_LATENCY);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    // Word storage, preloaded and inspected by benches through mem[].
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // True when the byte address falls inside the window owned by mem[].
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] offset;
        offset = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && (64'(offset) < MEM_BYTES);
    endfunction

    // Word index of a byte address; sub-word address bits are ignored.
    function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] offset;
        offset = (addr - BASE_ADDR) >> BYTE_SHIFT;
        return IDX_W'(offset);
    endfunction

    // Write channel state
    w_state_t              w_state;
    logic [7:0]            w_cnt;
    logic                  aw_full;
    logic                  w_full;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;
    logic                  awready_q;
    logic                  wready_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;

    // Read channel state
    r_state_t              r_state;
    logic [7:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    logic                  w_commit;
    logic                  aw_in_range;
    logic                  ar_in_range;
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W-1:0]      r_idx;

    // Protection bits carry no meaning for this model.
    logic unused_prot;
    assign unused_prot = &{1'b0, bus.awprot, bus.arprot};

    assign aw_in_range = addr_in_range(aw_addr_q);
    assign ar_in_range = addr_in_range(ar_addr_q);
    assign w_idx       = word_index(aw_addr_q);
    assign r_idx       = word_index(ar_addr_q);

    // The write lands in the array on the cycle the write wait period ends.
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_commit = 1'b0;
        case (w_state)
            W_IDLE:  w_commit = aw_full && w_full && (WR_LATENCY == 0);
            W_WAIT:  w_commit = (w_cnt == 8'd0);
            default: w_commit = 1'b0;
        endcase
    end

    // Write FSM: buffer AW and W independently, wait, then hold the response.
    // NOTE: reset here is synchronous, so it only sits inside the clocked branch, not the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: sequential state always uses non-blocking assignments so all registers update together.
            w_state   <= W_IDLE;
            w_cnt     <= '0;
            aw_full   <= 1'b0;
            w_full    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_full && w_full) begin
                        if (WR_LATENCY == 0) begin
                            bvalid_q <= 1'b1;
                            bresp_q  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
                            w_state  <= W_RESP;
                        end else begin
                            w_cnt   <= WR_LAT_M1;
                            w_state <= W_WAIT;
                        end
                    end else begin
                        if (bus.awvalid && awready_q) begin
                            aw_full   <= 1'b1;
                            aw_addr_q <= bus.awaddr;
                            awready_q <= 1'b0;
                        end else begin
                            awready_q <= !aw_full;
                        end
                        if (bus.wvalid && wready_q) begin
                            w_full   <= 1'b1;
                            w_data_q <= bus.wdata;
                            w_strb_q <= bus.wstrb;
                            wready_q <= 1'b0;
                        end else begin
                            wready_q <= !w_full;
                        end
                    end
                end
                W_WAIT: begin
                    if (w_cnt == 8'd0) begin
                        bvalid_q <= 1'b1;
                        bresp_q  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
                        w_state  <= W_RESP;
                    end else begin
                        w_cnt <= w_cnt - 8'd1;
                    end
                end
                W_RESP: begin
                    if (bus.bready) begin
                        bvalid_q  <= 1'b0;
                        aw_full   <= 1'b0;
                        w_full    <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Byte-masked array update on commit; out-of-range writes are dropped.
    // NOTE: the array is deliberately not reset so preloaded contents survive a reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_commit && aw_in_range) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb_q[b]) begin
                    mem[w_idx][8*b +: 8] <= w_data_q[8*b +: 8];
                end
            end
        end
    end

    // Read FSM: accept AR, wait RD_LATENCY cycles, sample and hold the response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= R_IDLE;
            r_cnt     <= '0;
            ar_addr_q <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (bus.arvalid && arready_q) begin
                        ar_addr_q <= bus.araddr;
                        arready_q <= 1'b0;
                        r_cnt     <= RD_LAT;
                        r_state   <= R_WAIT;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (r_cnt == 8'd0) begin
                        rvalid_q <= 1'b1;
                        if (ar_in_range) begin
                            rdata_q <= mem[r_idx];
                            rresp_q <= RESP_OKAY;
                        end else begin
                            rdata_q <= '0;
                            rresp_q <= RESP_SLVERR;
                        end
                        r_state <= R_RESP;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                R_RESP: begin
                    if (bus.rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state   <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_mem_model.sv
// Bench for axi_lite_mem_model: two instances (slow one at base 0, fast one
// at a non-zero base) driven by one shared master, checked against a word
// array reference model with directed scenarios plus random traffic.
module tb_axi_lite_mem_model;

    localparam int          WORDS  = 16;
    localparam logic [31:0] BASE_A = 32'h0000_0000;
    localparam logic [31:0] BASE_B = 32'h0000_1000;
    localparam int          RLAT_A = 3;
    localparam int          WLAT_A = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Which instance the shared master talks to: 0 = dut_a, 1 = dut_b.
    logic sel = 1'b0;

    logic        drv_awvalid = 1'b0, drv_wvalid = 1'b0, drv_bready = 1'b0;
    logic        drv_arvalid = 1'b0, drv_rready = 1'b0;
    logic [31:0] drv_awaddr = '0, drv_wdata = '0, drv_araddr = '0;
    logic [3:0]  drv_wstrb = '0;

    logic        obs_awready, obs_wready, obs_bvalid, obs_arready, obs_rvalid;
    logic [1:0]  obs_bresp, obs_rresp;
    logic [31:0] obs_rdata;

    axi_lite_mem_model_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
    axi_lite_mem_model_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_b ();

    assign bus_a.awvalid = drv_awvalid & ~sel;
    assign bus_a.awaddr  = drv_awaddr;
    assign bus_a.awprot  = 3'b000;
    assign bus_a.wvalid  = drv_wvalid & ~sel;
    assign bus_a.wdata   = drv_wdata;
    assign bus_a.wstrb   = drv_wstrb;
    assign bus_a.bready  = drv_bready & ~sel;
    assign bus_a.arvalid = drv_arvalid & ~sel;
    assign bus_a.araddr  = drv_araddr;
    assign bus_a.arprot  = 3'b000;
    assign bus_a.rready  = drv_rready & ~sel;

    assign bus_b.awvalid = drv_awvalid & sel;
    assign bus_b.awaddr  = drv_awaddr;
    assign bus_b.awprot  = 3'b000;
    assign bus_b.wvalid  = drv_wvalid & sel;
    assign bus_b.wdata   = drv_wdata;
    assign bus_b.wstrb   = drv_wstrb;
    assign bus_b.bready  = drv_bready & sel;
    assign bus_b.arvalid = drv_arvalid & sel;
    assign bus_b.araddr  = drv_araddr;
    assign bus_b.arprot  = 3'b000;
    assign bus_b.rready  = drv_rready & sel;

    assign obs_awready = sel ? bus_b.awready : bus_a.awready;
    assign obs_wready  = sel ? bus_b.wready  : bus_a.wready;
    assign obs_bvalid  = sel ? bus_b.bvalid  : bus_a.bvalid;
    assign obs_bresp   = sel ? bus_b.bresp   : bus_a.bresp;
    assign obs_arready = sel ? bus_b.arready : bus_a.arready;
    assign obs_rvalid  = sel ? bus_b.rvalid  : bus_a.rvalid;
    assign obs_rdata   = sel ? bus_b.rdata   : bus_a.rdata;
    assign obs_rresp   = sel ? bus_b.rresp   : bus_a.rresp;

    axi_lite_mem_model #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(WORDS), .BASE_ADDR(BASE_A),
        .RD_LATENCY(RLAT_A), .WR_LATENCY(WLAT_A)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

    axi_lite_mem_model #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(WORDS), .BASE_ADDR(BASE_B),
        .RD_LATENCY(0), .WR_LATENCY(0)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] model_mem [2][WORDS];

    function automatic logic [31:0] base_of(input logic s);
        return s ? BASE_B : BASE_A;
    endfunction

    // Word slot hit by a byte address, or -1 when outside the instance window.
    function automatic int model_index(input logic s, input logic [31:0] addr);
        longint a, b;
        a = longint'(addr);
        b = longint'(base_of(s));
        if (a >= b && a < b + WORDS * 4) return int'((a - b) / 4);
        return -1;
    endfunction

    task automatic model_write(input logic s, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb);
        int idx;
        idx = model_index(s, addr);
        if (idx >= 0) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model_mem[s][idx][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    // Number of array words in either instance that differ from the model.
    function automatic int mem_diffs();
        int d;
        d = 0;
        for (int i = 0; i < WORDS; i++) begin
            if (dut_a.mem[i] !== model_mem[0][i]) d++;
            if (dut_b.mem[i] !== model_mem[1][i]) d++;
        end
        return d;
    endfunction

    // ---------------- bus tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_txn(input logic [31:0] addr, input int hold,
                            output logic [31:0] data, output logic [1:0] resp,
                            output int lat, output logic held);
        int n;
        logic hs;
        drv_araddr  = addr;
        drv_arvalid = 1'b1;
        n = 0;
        do begin
            hs = obs_arready;
            tick();
            n++;
        end while (!hs && n < 50);
        drv_arvalid = 1'b0;
        if (!hs) check("ar_handshake_timeout", 0, 1);
        n = 0;
        while (!obs_rvalid && n < 300) begin
            tick();
            n++;
        end
        lat  = n;
        data = obs_rdata;
        resp = obs_rresp;
        held = obs_rvalid;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!obs_rvalid || obs_rdata !== data || obs_rresp !== resp) held = 1'b0;
        end
        drv_rready = 1'b1;
        tick();
        drv_rready = 1'b0;
        if (obs_rvalid) held = 1'b0;
    endtask

    // w_lead > 0: W presented that many cycles before AW; < 0: AW leads.
    task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lead, input int hold,
                             output logic [1:0] resp, output logic held,
                             output logic wready_low);
        int c, n, aw_start, w_start;
        logic aw_done, w_done, aw_hs, w_hs;
        aw_start = (w_lead > 0) ? w_lead : 0;
        w_start  = (w_lead < 0) ? -w_lead : 0;
        aw_done = 1'b0;
        w_done  = 1'b0;
        wready_low = 1'b1;
        drv_awaddr = addr;
        drv_wdata  = data;
        drv_wstrb  = strb;
        c = 0;
        while (!(aw_done && w_done) && c < 50) begin
            drv_awvalid = !aw_done && (c >= aw_start);
            drv_wvalid  = !w_done && (c >= w_start);
            if (w_done && !aw_done && obs_wready) wready_low = 1'b0;
            aw_hs = drv_awvalid && obs_awready;
            w_hs  = drv_wvalid && obs_wready;
            tick();
            c++;
            if (aw_hs) aw_done = 1'b1;
            if (w_hs)  w_done  = 1'b1;
        end
        drv_awvalid = 1'b0;
        drv_wvalid  = 1'b0;
        if (!(aw_done && w_done)) check("aw_w_handshake_timeout", 0, 1);
        n = 0;
        while (!obs_bvalid && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check("bvalid_timeout", 0, 1);
        resp = obs_bresp;
        held = obs_bvalid;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!obs_bvalid || obs_bresp !== resp) held = 1'b0;
        end
        drv_bready = 1'b1;
        tick();
        drv_bready = 1'b0;
        if (obs_bvalid) held = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    logic [31:0] rd, old_val, new_val, addr;
    logic [1:0]  rr, br;
    logic [3:0]  strb;
    logic        held, wlow, seen, s;
    int          lat, idx, n;

    initial begin
        // Preload both arrays and the model with the same contents.
        for (int i = 0; i < WORDS; i++) begin
            model_mem[0][i] = $urandom;
            model_mem[1][i] = $urandom;
        end
        model_mem[0][2] = 32'hDEAD_BEEF;
        model_mem[0][1] = 32'hAABB_CCDD;
        for (int i = 0; i < WORDS; i++) begin
            dut_a.mem[i] = model_mem[0][i];
            dut_b.mem[i] = model_mem[1][i];
        end

        // 1. Reset held for two edges, then released.
        tick();
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            #1;
            check("rst_readys", {obs_awready, obs_wready, obs_arready}, 3'b000);
            check("rst_valids", {obs_bvalid, obs_rvalid}, 2'b00);
            check("rst_rdata_resp", {obs_rdata, obs_rresp, obs_bresp}, 36'h0);
        end
        sel = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            #1;
            check("post_rst_readys", {obs_awready, obs_wready, obs_arready}, 3'b111);
        end
        sel = 1'b0;
        #1;
        check("preload_intact", mem_diffs(), 0);

        // 2. Read with three wait states, held off by RREADY low for 5 cycles.
        read_txn(32'h8, 5, rd, rr, lat, held);
        check("rd_latency", lat, RLAT_A + 1);
        check("rd_data", rd, 32'hDEAD_BEEF);
        check("rd_resp", rr, 2'b00);
        check("rd_hold", held, 1);

        // 3. W three cycles ahead of AW, partial strobe.
        write_txn(32'h4, 32'h1122_3344, 4'b0101, 3, 2, br, held, wlow);
        model_write(1'b0, 32'h4, 32'h1122_3344, 4'b0101);
        check("wr_resp", br, 2'b00);
        check("wr_wready_low", wlow, 1);
        check("wr_b_hold", held, 1);
        check("wr_mem1", dut_a.mem[1], 32'hAA22_CC44);

        // 4. Out-of-range write and read just past the array.
        write_txn(32'h40, 32'hFFFF_FFFF, 4'hF, 0, 0, br, held, wlow);
        check("oor_bresp", br, 2'b10);
        check("oor_no_change", mem_diffs(), 0);
        read_txn(32'h40, 0, rd, rr, lat, held);
        check("oor_rresp", rr, 2'b10);
        check("oor_rdata", rd, 32'h0);

        // 5. Zero-latency instance: AW, W and AR to word 3 in one cycle.
        sel = 1'b1;
        #1;
        addr    = BASE_B + 32'hC;
        old_val = model_mem[1][3];
        new_val = $urandom;
        check("col_readys", {obs_awready, obs_wready, obs_arready}, 3'b111);
        drv_awaddr = addr;  drv_wdata = new_val; drv_wstrb = 4'hF; drv_araddr = addr;
        drv_awvalid = 1'b1; drv_wvalid = 1'b1;   drv_arvalid = 1'b1;
        tick();
        drv_awvalid = 1'b0; drv_wvalid = 1'b0;   drv_arvalid = 1'b0;
        n = 0;
        while (!(obs_rvalid && obs_bvalid) && n < 20) begin
            tick();
            n++;
        end
        check("col_both_valid", {obs_rvalid, obs_bvalid}, 2'b11);
        check("col_rdata_old", obs_rdata, old_val);
        check("col_resps", {obs_rresp, obs_bresp}, 4'b0000);
        drv_rready = 1'b1;
        tick();
        drv_rready = 1'b0;
        check("col_r_done_b_pending", {obs_rvalid, obs_bvalid}, 2'b01);
        drv_bready = 1'b1;
        tick();
        drv_bready = 1'b0;
        check("col_b_done", obs_bvalid, 0);
        model_write(1'b1, addr, new_val, 4'hF);
        check("col_mem3_new", dut_b.mem[3], new_val);
        read_txn(addr, 1, rd, rr, lat, held);
        check("col_readback", rd, new_val);

        // 6. Reset while the slow instance sits in R_WAIT and W_WAIT.
        sel = 1'b0;
        #1;
        check("rw_readys", {obs_awready, obs_wready, obs_arready}, 3'b111);
        drv_awaddr = 32'h14; drv_wdata = 32'h5A5A_5A5A; drv_wstrb = 4'hF; drv_araddr = 32'h18;
        drv_awvalid = 1'b1;  drv_wvalid = 1'b1;          drv_arvalid = 1'b1;
        tick();
        drv_awvalid = 1'b0;  drv_wvalid = 1'b0;          drv_arvalid = 1'b0;
        tick();
        rst_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (obs_rvalid || obs_bvalid) seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (obs_rvalid || obs_bvalid) seen = 1'b1;
        end
        check("rst_mid_no_resp", seen, 0);
        check("rst_mid_no_write", mem_diffs(), 0);
        write_txn(32'h14, 32'h0BAD_F00D, 4'hF, -1, 1, br, held, wlow);
        model_write(1'b0, 32'h14, 32'h0BAD_F00D, 4'hF);
        check("rst_mid_new_wr", br, 2'b00);
        read_txn(32'h14, 0, rd, rr, lat, held);
        check("rst_mid_new_rd", rd, 32'h0BAD_F00D);

        // Random traffic against the model, including sub-word and out-of-window addresses.
        for (int t = 0; t < 80; t++) begin
            s = 1'($urandom_range(0, 1));
            sel = s;
            #1;
            if ($urandom_range(0, 7) == 0)
                addr = base_of(s) - 32'(4 * $urandom_range(1, 4));
            else
                addr = base_of(s) + 32'(4 * $urandom_range(0, WORDS + 3)) + 32'($urandom_range(0, 3));
            idx = model_index(s, addr);
            if ($urandom_range(0, 1) == 1) begin
                new_val = $urandom;
                strb    = 4'($urandom_range(0, 15));
                write_txn(addr, new_val, strb, $urandom_range(0, 4) - 2, $urandom_range(0, 3),
                          br, held, wlow);
                model_write(s, addr, new_val, strb);
                check("rnd_bresp", br, (idx >= 0) ? 2'b00 : 2'b10);
                check("rnd_b_hold", held, 1);
            end else begin
                read_txn(addr, $urandom_range(0, 3), rd, rr, lat, held);
                check("rnd_rdata", rd, (idx >= 0) ? model_mem[s][idx] : 32'h0);
                check("rnd_rresp", rr, (idx >= 0) ? 2'b00 : 2'b10);
                check("rnd_rlat", lat, s ? 1 : RLAT_A + 1);
                check("rnd_r_hold", held, 1);
            end
        end
        #1;
        check("final_mem", mem_diffs(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
